// File: rtl/fp_wb_arb.sv
// ---------------------------------------------------------------------------
// fp_wb_arb - floating-point register file writeback arbiter.
//
// Two producers (FPU pipeline, FP load path) hand results over valid/ready.
// Each producer has its own DEPTH-entry FIFO. The two FIFO heads are drained
// round-robin into one registered write port. There is at most one write per
// cycle. The minimum latency from handshake to fp_we_o is 2 cycles.
//
// Optional feature macro: FP_WB_FFLAGS_EN
//   When defined, FPU entries also carry 5 exception-flag bits. These bits are
//   OR-accumulated into a sticky fflags_acc_o register on each FPU grant.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush_i                 synchronous flush of both FIFOs and of fp_we_o
//   fpu_valid_i/ready_o     FPU result handshake; fpu_rd_i, fpu_data_i payload
//   ld_valid_i/ready_o      load result handshake; ld_rd_i, ld_data_i payload
//   fp_we_o, rd_reg_o,
//   fp_wdata_o              registered register-file write port
//   wb_idle_o               both FIFOs empty and no write in flight
//   fpu_fflags_i            (FP_WB_FFLAGS_EN) flags that travel with the FPU result
//   fflags_clr_i            (FP_WB_FFLAGS_EN) clears the accumulator
//   fflags_acc_o            (FP_WB_FFLAGS_EN) sticky accumulated flags
// ---------------------------------------------------------------------------
module fp_wb_arb #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [4:0]  fpu_rd_i,
  input  logic [31:0] fpu_data_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
`ifdef FP_WB_FFLAGS_EN
  input  logic [4:0]  fpu_fflags_i,
  input  logic        fflags_clr_i,
  output logic [4:0]  fflags_acc_o,
`endif
  output logic        fp_we_o,
  output logic [4:0]  rd_reg_o,
  output logic [31:0] fp_wdata_o,
  output logic        wb_idle_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the index bits match.
  typedef logic [AW:0] ptr_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [4:0]  fpu_rd_mem   [DEPTH];
  logic [31:0] fpu_data_mem [DEPTH];
  logic [4:0]  ld_rd_mem    [DEPTH];
  logic [31:0] ld_data_mem  [DEPTH];
`ifdef FP_WB_FFLAGS_EN
  logic [4:0]  fpu_ff_mem   [DEPTH];
`endif

  ptr_t fpu_wptr_q, fpu_wptr_d, fpu_rptr_q, fpu_rptr_d;
  ptr_t ld_wptr_q,  ld_wptr_d,  ld_rptr_q,  ld_rptr_d;

  logic fpu_full, fpu_empty, ld_full, ld_empty;
  logic fpu_push, ld_push;
  logic gnt_fpu, gnt_ld;

  logic rr_q, rr_d;  // 0: FPU has priority, 1: load has priority

  logic        fp_we_q,    fp_we_d;
  logic [4:0]  rd_reg_q,   rd_reg_d;
  logic [31:0] fp_wdata_q, fp_wdata_d;

  assign fpu_full  = (fpu_wptr_q[AW] != fpu_rptr_q[AW]) &&
                     (fpu_wptr_q[AW-1:0] == fpu_rptr_q[AW-1:0]);
  assign fpu_empty = (fpu_wptr_q == fpu_rptr_q);
  assign ld_full   = (ld_wptr_q[AW] != ld_rptr_q[AW]) &&
                     (ld_wptr_q[AW-1:0] == ld_rptr_q[AW-1:0]);
  assign ld_empty  = (ld_wptr_q == ld_rptr_q);

  // Ready depends only on the pointers. A pop in the same cycle does not free
  // a slot for a push in that cycle.
  assign fpu_ready_o = ~fpu_full;
  assign ld_ready_o  = ~ld_full;

  assign fpu_push = fpu_valid_i & ~fpu_full & ~flush_i;
  assign ld_push  = ld_valid_i  & ~ld_full  & ~flush_i;

  // Storage has no reset. A head is read only while its FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (fpu_push) begin
      fpu_rd_mem[fpu_wptr_q[AW-1:0]]   <= fpu_rd_i;
      fpu_data_mem[fpu_wptr_q[AW-1:0]] <= fpu_data_i;
`ifdef FP_WB_FFLAGS_EN
      fpu_ff_mem[fpu_wptr_q[AW-1:0]]   <= fpu_fflags_i;
`endif
    end
    if (ld_push) begin
      ld_rd_mem[ld_wptr_q[AW-1:0]]   <= ld_rd_i;
      ld_data_mem[ld_wptr_q[AW-1:0]] <= ld_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. Flush suppresses every grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_fpu = 1'b0;
    gnt_ld  = 1'b0;
    rr_d    = rr_q;
    if (flush_i) begin
      rr_d = 1'b0;
    end else if (!fpu_empty && (ld_empty || !rr_q)) begin
      gnt_fpu = 1'b1;
      rr_d    = 1'b1;
    end else if (!ld_empty) begin
      gnt_ld = 1'b1;
      rr_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer next-state. Flush empties both FIFOs by zeroing the pointers.
  // ---------------------------------------------------------------------------
  always_comb begin
    fpu_wptr_d = fpu_wptr_q;
    fpu_rptr_d = fpu_rptr_q;
    ld_wptr_d  = ld_wptr_q;
    ld_rptr_d  = ld_rptr_q;
    if (flush_i) begin
      fpu_wptr_d = '0;
      fpu_rptr_d = '0;
      ld_wptr_d  = '0;
      ld_rptr_d  = '0;
    end else begin
      if (fpu_push) fpu_wptr_d = fpu_wptr_q + ptr_t'(1);
      if (gnt_fpu)  fpu_rptr_d = fpu_rptr_q + ptr_t'(1);
      if (ld_push)  ld_wptr_d  = ld_wptr_q + ptr_t'(1);
      if (gnt_ld)   ld_rptr_d  = ld_rptr_q + ptr_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Write port next-state. Address and data hold their values when no source
  // is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    fp_we_d    = gnt_fpu | gnt_ld;
    rd_reg_d   = rd_reg_q;
    fp_wdata_d = fp_wdata_q;
    if (gnt_fpu) begin
      rd_reg_d   = fpu_rd_mem[fpu_rptr_q[AW-1:0]];
      fp_wdata_d = fpu_data_mem[fpu_rptr_q[AW-1:0]];
    end else if (gnt_ld) begin
      rd_reg_d   = ld_rd_mem[ld_rptr_q[AW-1:0]];
      fp_wdata_d = ld_data_mem[ld_rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_wptr_q <= '0;
      fpu_rptr_q <= '0;
      ld_wptr_q  <= '0;
      ld_rptr_q  <= '0;
      rr_q       <= 1'b0;
      fp_we_q    <= 1'b0;
      rd_reg_q   <= '0;
      fp_wdata_q <= '0;
    end else begin
      fpu_wptr_q <= fpu_wptr_d;
      fpu_rptr_q <= fpu_rptr_d;
      ld_wptr_q  <= ld_wptr_d;
      ld_rptr_q  <= ld_rptr_d;
      rr_q       <= rr_d;
      fp_we_q    <= fp_we_d;
      rd_reg_q   <= rd_reg_d;
      fp_wdata_q <= fp_wdata_d;
    end
  end

  assign fp_we_o    = fp_we_q;
  assign rd_reg_o   = rd_reg_q;
  assign fp_wdata_o = fp_wdata_q;
  assign wb_idle_o  = fpu_empty & ld_empty & ~fp_we_q;

`ifdef FP_WB_FFLAGS_EN
  // ---------------------------------------------------------------------------
  // Sticky flag accumulator. A clear in the same cycle as an FPU grant keeps
  // only the flags of the granted entry. Flush leaves the accumulator alone.
  // ---------------------------------------------------------------------------
  logic [4:0] fflags_acc_q, fflags_acc_d;
  logic [4:0] acc_base;

  always_comb begin
    acc_base     = fflags_clr_i ? 5'd0 : fflags_acc_q;
    fflags_acc_d = acc_base;
    if (gnt_fpu) begin
      fflags_acc_d = acc_base | fpu_ff_mem[fpu_rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_acc_q <= '0;
    end else begin
      fflags_acc_q <= fflags_acc_d;
    end
  end

  assign fflags_acc_o = fflags_acc_q;
`endif

endmodule

// File: tb/tb_fp_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_fp_wb_arb - self-checking bench for fp_wb_arb.
// A reference model keeps one queue per source plus the round-robin bit.
// Each expected write is pushed into a scoreboard queue. A monitor pops that
// queue whenever the DUT shows fp_we and compares the payload.
// ---------------------------------------------------------------------------
module tb_fp_wb_arb;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        fpu_valid = 1'b0, ld_valid = 1'b0;
  logic        fpu_ready, ld_ready;
  logic [4:0]  fpu_rd = '0, ld_rd = '0;
  logic [31:0] fpu_data = '0, ld_data = '0;
  logic        fp_we, wb_idle;
  logic [4:0]  rd_reg;
  logic [31:0] fp_wdata;
  logic [4:0]  fpu_fflags = '0;
  logic        fflags_clr = 1'b0;
  logic [4:0]  fflags_acc;
  logic [4:0]  ffin;

  always #5 clk = ~clk;

  fp_wb_arb #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .fpu_valid_i  (fpu_valid),
    .fpu_ready_o  (fpu_ready),
    .fpu_rd_i     (fpu_rd),
    .fpu_data_i   (fpu_data),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_rd_i      (ld_rd),
    .ld_data_i    (ld_data),
`ifdef FP_WB_FFLAGS_EN
    .fpu_fflags_i (fpu_fflags),
    .fflags_clr_i (fflags_clr),
    .fflags_acc_o (fflags_acc),
`endif
    .fp_we_o      (fp_we),
    .rd_reg_o     (rd_reg),
    .fp_wdata_o   (fp_wdata),
    .wb_idle_o    (wb_idle)
  );

`ifdef FP_WB_FFLAGS_EN
  assign ffin = fpu_fflags;
`else
  assign ffin = 5'd0;
  assign fflags_acc = 5'd0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  ff;
  } ent_t;

  ent_t fq[$];
  ent_t lq[$];
  ent_t exp_q[$];
  bit          m_rr, m_we;
  logic [4:0]  m_rd  = '0;
  logic [4:0]  m_acc = '0;
  logic [31:0] m_data = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It applies one cycle of the arbitration rules per clock edge.
  initial begin : model
    ent_t g;
    int   fs, ls;
    bit   gf, gl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fq.delete(); lq.delete(); exp_q.delete();
        m_rr = 0; m_we = 0; m_rd = '0; m_data = '0; m_acc = '0;
      end else if (flush) begin
        fq.delete(); lq.delete();
        m_rr = 0; m_we = 0;
        if (fflags_clr) m_acc = '0;
      end else begin
        fs = fq.size();
        ls = lq.size();
        gf = (fs > 0) && (ls == 0 || !m_rr);
        gl = (ls > 0) && !gf;
        if (gf) m_acc = (fflags_clr ? 5'd0 : m_acc) | fq[0].ff;
        else if (fflags_clr) m_acc = '0;
        if (gf) begin
          g = fq.pop_front(); m_rr = 1;
        end else if (gl) begin
          g = lq.pop_front(); m_rr = 0;
        end
        m_we = gf || gl;
        if (m_we) begin
          m_rd = g.rd; m_data = g.data;
          exp_q.push_back(g);
        end
        if (fpu_valid && fs < DEPTH) fq.push_back('{fpu_rd, fpu_data, ffin});
        if (ld_valid && ls < DEPTH)  lq.push_back('{ld_rd, ld_data, 5'd0});
      end
    end
  end

  // Monitor. Outputs are sampled on the falling edge.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("fp_we", fp_we, exp_q.size() != 0);
        if (fp_we && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wb_rd", rd_reg, e.rd);
          chk("wb_data", fp_wdata, e.data);
        end else begin
          exp_q.delete();
          chk("hold_rd", rd_reg, m_rd);
          chk("hold_data", fp_wdata, m_data);
        end
        chk("fpu_ready", fpu_ready, fq.size() < DEPTH);
        chk("ld_ready", ld_ready, lq.size() < DEPTH);
        chk("wb_idle", wb_idle, fq.size() == 0 && lq.size() == 0 && !m_we);
`ifdef FP_WB_FFLAGS_EN
        chk("fflags_acc", fflags_acc, m_acc);
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    fpu_valid = 0; ld_valid = 0; flush = 0; fflags_clr = 0; fpu_fflags = '0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit saw_nready;
    repeat (3) tick();
    chk("rst_we", fp_we, 0);
    chk("rst_rd", rd_reg, 0);
    chk("rst_data", fp_wdata, 0);
    chk("rst_fpu_ready", fpu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_idle", wb_idle, 1);
    rst_n = 1;
    tick();

    // Simultaneous pushes from reset. The FPU write comes first, then the load write.
    fpu_valid = 1; fpu_rd = 5'd1; fpu_data = 32'h11111111;
    ld_valid = 1;  ld_rd = 5'd2;  ld_data = 32'h22222222;
    tick(); idle_in();
    chk("t2_c1_we", fp_we, 0);
    tick();
    chk("t2_c2_rd", rd_reg, 1);
    chk("t2_c2_data", fp_wdata, 32'h11111111);
    tick();
    chk("t2_c3_we", fp_we, 1);
    chk("t2_c3_rd", rd_reg, 2);
    chk("t2_c3_data", fp_wdata, 32'h22222222);
    tick();

    // Single FPU push. fp_we is high in cycle 2 only.
    fpu_valid = 1; fpu_rd = 5'd3; fpu_data = 32'h3F800000;
    tick(); idle_in();
    chk("t1_c1_we", fp_we, 0);
    tick();
    chk("t1_c2_we", fp_we, 1);
    chk("t1_c2_rd", rd_reg, 3);
    chk("t1_c2_data", fp_wdata, 32'h3F800000);
    tick();
    chk("t1_c3_we", fp_we, 0);
    chk("t1_c3_idle", wb_idle, 1);

    // Four back-to-back load pushes. One write per cycle in order.
    for (int i = 0; i < 7; i++) begin
      ld_valid = (i < 4); ld_rd = 5'(4 + i); ld_data = $urandom;
      tick();
      chk("t3_ld_ready", ld_ready, 1);
      if (i >= 1 && i <= 4) begin
        chk("t3_we", fp_we, 1);
        chk("t3_rd", rd_reg, 5'(4 + i - 1));
      end
    end
    idle_in();

    // FPU held valid for 6 cycles while the load FIFO stays saturated.
    saw_nready = 0;
    for (int i = 0; i < 10; i++) begin
      fpu_valid = (i < 6); fpu_rd = 5'(8 + i); fpu_data = 32'hF000_0000 | i;
      ld_valid = 1;        ld_rd = 5'(20 + i); ld_data = 32'hA000_0000 | i;
      tick();
      if (!fpu_ready) saw_nready = 1;
    end
    idle_in();
    chk("t4_fpu_ready_dropped", saw_nready, 1);
    repeat (6) tick();

    // Fill both FIFOs, then flush.
    for (int i = 0; i < 3; i++) begin
      fpu_valid = 1; fpu_rd = 5'(i); fpu_data = $urandom;
      ld_valid = 1;  ld_rd = 5'(i + 16); ld_data = $urandom;
      tick();
    end
    idle_in();
    flush = 1;
    tick();
    flush = 0;
    chk("t5_we", fp_we, 0);
    chk("t5_fpu_ready", fpu_ready, 1);
    chk("t5_ld_ready", ld_ready, 1);
    chk("t5_idle", wb_idle, 1);
    repeat (3) begin
      tick();
      chk("t5_no_stale", fp_we, 0);
    end

`ifdef FP_WB_FFLAGS_EN
    fflags_clr = 1;
    tick(); fflags_clr = 0;
    fpu_valid = 1; fpu_rd = 5'd5; fpu_data = 32'h1; fpu_fflags = 5'b00001;
    tick();
    fpu_rd = 5'd6; fpu_data = 32'h2; fpu_fflags = 5'b10000;
    tick(); idle_in();
    repeat (3) tick();
    chk("t6_acc_or", fflags_acc, 5'b10001);
    fpu_valid = 1; fpu_rd = 5'd7; fpu_data = 32'h3; fpu_fflags = 5'b00100;
    tick(); idle_in();
    fflags_clr = 1;  // same cycle as the grant of the 5'b00100 entry
    tick(); fflags_clr = 0;
    chk("t6_acc_clr_grant", fflags_acc, 5'b00100);
    repeat (2) tick();
`endif

    // Randomized traffic, with an asynchronous reset partway through.
    for (int i = 0; i < 600; i++) begin
      fpu_valid  = ($urandom_range(0, 3) != 0);
      fpu_rd     = 5'($urandom);
      fpu_data   = $urandom;
      fpu_fflags = 5'($urandom);
      ld_valid   = ($urandom_range(0, 2) != 0);
      ld_rd      = 5'($urandom);
      ld_data    = $urandom;
      flush      = ($urandom_range(0, 40) == 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      if (i == 300) begin
        #2 rst_n = 0;
        #1;
        chk("arst_we", fp_we, 0);
        chk("arst_rd", rd_reg, 0);
        chk("arst_data", fp_wdata, 0);
        chk("arst_fpu_ready", fpu_ready, 1);
        chk("arst_ld_ready", ld_ready, 1);
        chk("arst_idle", wb_idle, 1);
`ifdef FP_WB_FFLAGS_EN
        chk("arst_acc", fflags_acc, 0);
`endif
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end
    idle_in();
    repeat (8) tick();
    chk("drain_idle", wb_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
